// File: rtl/controlador_divisao.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// WIDTH iteration cycles, single-cycle completion pulse, divide-by-zero flag.
module controlador_divisao #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iniciar,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic             ocupado,
    output logic             pronto,
    output logic [WIDTH-1:0] quociente,
    output logic [WIDTH-1:0] resto,
    output logic             erro_div_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);

    typedef enum logic [1:0] {OCIOSO, CALCULO, CONCLUIDO} estado_t;

    estado_t          estado, proximo;
    logic [WIDTH-1:0] dvd;          // captured dividend, shifted out MSB-first
    logic [WIDTH-1:0] dsr;          // captured divisor
    logic [WIDTH-1:0] resto_parc;   // working remainder
    logic [WIDTH-1:0] quoc_parc;    // working quotient
    logic [CW-1:0]    contador;

    logic [WIDTH:0]   parcial, diferenca;
    logic             cabe;
    logic [WIDTH-1:0] resto_prox, quoc_prox;

    // State register
    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= proximo;
    end

    // Next-state and status outputs; a zero divisor skips the iteration phase
    always_comb begin
        proximo = estado;
        ocupado = 1'b0;
        pronto  = 1'b0;
        case (estado)
            OCIOSO: begin
                if (iniciar) proximo = (divisor != '0) ? CALCULO : CONCLUIDO;
            end
            CALCULO: begin
                ocupado = 1'b1;
                if (contador == ULTIMO) proximo = CONCLUIDO;
            end
            CONCLUIDO: begin
                ocupado = 1'b1;
                pronto  = 1'b1;
                proximo = OCIOSO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    // One restoring step: bring down the next dividend bit, subtract if it fits
    always_comb begin
        parcial    = {resto_parc, dvd[WIDTH-1]};
        diferenca  = parcial - {1'b0, dsr};
        cabe       = (parcial >= {1'b0, dsr});
        resto_prox = cabe ? diferenca[WIDTH-1:0] : parcial[WIDTH-1:0];
        quoc_prox  = {quoc_parc[WIDTH-2:0], cabe};
    end

    // Datapath: capture on accept, iterate in CALCULO, publish results only on the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd           <= '0;
            dsr           <= '0;
            resto_parc    <= '0;
            quoc_parc     <= '0;
            contador      <= '0;
            quociente     <= '0;
            resto         <= '0;
            erro_div_zero <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        dvd           <= dividendo;
                        dsr           <= divisor;
                        resto_parc    <= '0;
                        quoc_parc     <= '0;
                        contador      <= '0;
                        quociente     <= '0;
                        resto         <= '0;
                        erro_div_zero <= (divisor == '0);
                    end
                end
                CALCULO: begin
                    dvd        <= dvd << 1;
                    resto_parc <= resto_prox;
                    quoc_parc  <= quoc_prox;
                    contador   <= contador + CW'(1);
                    if (contador == ULTIMO) begin
                        quociente <= quoc_prox;
                        resto     <= resto_prox;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_controlador_divisao.sv
// Directed + randomized bench for controlador_divisao against an arithmetic model.
module tb_controlador_divisao;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, iniciar;
    logic [W-1:0] dividendo, divisor;
    logic         ocupado, pronto, erro_div_zero;
    logic [W-1:0] quociente, resto;

    int checks = 0;
    int errors = 0;

    controlador_divisao #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .iniciar(iniciar),
        .dividendo(dividendo), .divisor(divisor),
        .ocupado(ocupado), .pronto(pronto),
        .quociente(quociente), .resto(resto),
        .erro_div_zero(erro_div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Start one operation, scramble the operand inputs after capture, and check
    // latency, results and the return to idle against plain integer arithmetic.
    task automatic run_op(input int a, input int b, input string tag);
        int n;
        int eq, er, el;
        eq = (b != 0) ? a / b : 0;
        er = (b != 0) ? a % b : 0;
        el = (b != 0) ? W : 0;
        @(negedge clk);
        iniciar = 1'b1; dividendo = W'(a); divisor = W'(b);
        @(posedge clk); #1;
        iniciar = 1'b0; dividendo = W'($urandom); divisor = W'($urandom);
        n = 0;
        while (!pronto && n < 20) begin
            chk({tag, "_busy"}, ocupado, 1);
            chk({tag, "_hidden"}, {quociente, resto}, 0);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, el);
        chk({tag, "_q"}, quociente, eq);
        chk({tag, "_r"}, resto, er);
        chk({tag, "_err"}, erro_div_zero, (b == 0));
        @(posedge clk); #1;
        chk({tag, "_idle"}, {ocupado, pronto}, 0);
        chk({tag, "_hold"}, {erro_div_zero, quociente, resto}, {(b == 0), W'(eq), W'(er)});
    endtask

    initial begin
        int last, pulses, na, nb;
        rst = 1'b1; iniciar = 1'b0; dividendo = '0; divisor = '0;

        // Reset, with iniciar asserted to show reset wins
        @(negedge clk); iniciar = 1'b1; dividendo = 4'd13; divisor = 4'd4;
        @(posedge clk); #1;
        chk("reset", {ocupado, pronto, erro_div_zero, quociente, resto}, 0);
        @(negedge clk); rst = 1'b0; iniciar = 1'b0;

        // Directed cases
        run_op(13, 4, "d13_4");
        run_op(15, 1, "d15_1");
        run_op(2, 9, "d2_9");
        run_op(7, 0, "d7_0");
        run_op(6, 3, "d6_3");

        // Second start while busy is ignored; operand changes have no effect
        @(negedge clk); iniciar = 1'b1; dividendo = 4'd9; divisor = 4'd2;
        @(posedge clk); #1; iniciar = 1'b0;              // edge k
        chk("ign_busy_k", ocupado, 1);
        @(posedge clk); #1;                              // edge k+1
        chk("ign_busy_k1", ocupado, 1);
        iniciar = 1'b1; dividendo = 4'd15; divisor = 4'd5;
        @(posedge clk); #1;                              // edge k+2
        iniciar = 1'b0; dividendo = 4'd3; divisor = 4'd7;
        chk("ign_busy_k2", {ocupado, pronto}, 2'b10);
        @(posedge clk); #1;                              // edge k+3
        chk("ign_busy_k3", {ocupado, pronto}, 2'b10);
        @(posedge clk); #1;                              // edge k+4
        chk("ign_done", {ocupado, pronto, quociente, resto}, {2'b11, 4'd4, 4'd1});
        @(posedge clk); #1;                              // edge k+5
        chk("ign_idle", {ocupado, pronto}, 0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("ign_not_queued", {ocupado, pronto, quociente, resto}, {2'b00, 4'd4, 4'd1});
        end

        // Reset aborts a running operation without pronto
        @(negedge clk); iniciar = 1'b1; dividendo = 4'd14; divisor = 4'd3;
        @(posedge clk); #1; iniciar = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_outs", {ocupado, pronto, erro_div_zero, quociente, resto}, 0);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_quiet", {ocupado, pronto}, 0);
        end
        run_op(14, 3, "d14_3");

        // Continuous iniciar: back-to-back operations every W+2 cycles
        @(negedge clk); iniciar = 1'b1; dividendo = 4'd10; divisor = 4'd3;
        last = -1; pulses = 0;
        for (int cyc = 0; cyc < 60 && pulses < 4; cyc++) begin
            @(posedge clk); #1;
            if (pronto) begin
                chk("b2b_res", {quociente, resto}, {4'd3, 4'd1});
                if (last >= 0) chk("b2b_period", cyc - last, W + 2);
                last = cyc;
                pulses++;
            end
        end
        chk("b2b_pulses", pulses, 4);
        @(negedge clk); iniciar = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1 chk("b2b_drain", ocupado, 0);

        // Exhaustive sweep, zero divisor included
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(a, b, "sweep");

        // Random operations
        repeat (30) begin
            na = $urandom_range(15, 0);
            nb = $urandom_range(15, 0);
            run_op(na, nb, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/controlador_divisao.md
CONTROLADOR_DIVISAO -- requirements
Module: controlador_divisao

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; the block SHALL be correct for any WIDTH >= 2.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  synchronous reset, active-high.
REQ-005 Port: iniciar  input  1  start request, sampled on rising edge.
REQ-006 Port: dividendo  input  WIDTH  unsigned dividend, captured on accepted start.
REQ-007 Port: divisor  input  WIDTH  unsigned divisor, captured on accepted start.
REQ-008 Port: ocupado  output  1  high while an operation is in progress; start is not accepted while high.
REQ-009 Port: pronto  output  1  single-cycle completion pulse.
REQ-010 Port: quociente  output  WIDTH  registered quotient.
REQ-011 Port: resto  output  WIDTH  registered remainder.
REQ-012 Port: erro_div_zero  output  1  registered flag: last operation had divisor = 0.

Function
REQ-013 The FSM SHALL have exactly three states: OCIOSO, CALCULO, CONCLUIDO.
REQ-014 OCIOSO: ocupado=0, pronto=0; on edge k with iniciar=1, capture operands, clear quociente/resto/erro_div_zero, load iteration counter=0.
REQ-015 Edge-k transition SHALL go to CALCULO if captured divisor != 0, else directly to CONCLUIDO with erro_div_zero=1, quociente=0, resto=0.
REQ-016 CALCULO: ocupado=1; each edge performs one restoring step: partial remainder (WIDTH+1 bits internally) = {rem, next dividend bit MSB-first}; if >= divisor, subtract and shift quotient bit 1, else shift 0.
REQ-017 CALCULO SHALL last exactly WIDTH cycles (edges k+1 .. k+WIDTH); the edge performing the final step SHALL load quociente/resto and move to CONCLUIDO.
REQ-018 CONCLUIDO: ocupado=1, pronto=1 for exactly one cycle; next edge returns to OCIOSO unconditionally.
REQ-019 Latency: pronto high in cycle after edge k+WIDTH for nonzero divisor (WIDTH+1 cycles after accept), in cycle after edge k for zero divisor.
REQ-020 iniciar while ocupado=1 (CALCULO or CONCLUIDO) SHALL be ignored and not queued.
REQ-021 Changes on dividendo/divisor after capture SHALL NOT affect the running operation.
REQ-022 quociente, resto, erro_div_zero SHALL hold their values from completion until the next accepted start; intermediate values SHALL NOT appear on them during CALCULO.
REQ-023 Results SHALL satisfy quociente*divisor + resto = dividendo and resto < divisor for all nonzero divisors; no overflow is possible.
REQ-024 iniciar held high continuously SHALL produce back-to-back operations: one accept per return to OCIOSO.

Reset
REQ-025 rst=1 at an edge SHALL force OCIOSO and ocupado=0, pronto=0, quociente=0, resto=0, erro_div_zero=0, counter=0.
REQ-026 rst SHALL take priority over iniciar and abort any operation mid-CALCULO or CONCLUIDO without emitting pronto.
REQ-027 After rst deasserts, the first edge with iniciar=1 SHALL be accepted normally.

Verification
REQ-028 WIDTH=4, 13/4: iniciar at edge k -> pronto in cycle after edge k+4, quociente=3, resto=1, erro_div_zero=0.
REQ-029 15/1 -> quociente=15, resto=0; 2/9 -> quociente=0, resto=2; exhaustive 16x15 nonzero-divisor sweep matches REQ-023.
REQ-030 7/0 -> pronto in cycle after edge k, erro_div_zero=1, quociente=0, resto=0; next start with 6/3 clears flag, gives 2, 0.
REQ-031 Start 9/2, pulse iniciar with 15/5 at edge k+2 and change operand inputs -> result 4, 1; second request not executed; ocupado=1 edges k..k+5.
REQ-032 Start 14/3, assert rst at edge k+2 -> all outputs 0 next cycle, no pronto; subsequent start 14/3 -> 4, 2.
REQ-033 iniciar held high with fixed 10/3 -> pronto every WIDTH+2 cycles, each result 3, 1.
